// File: rtl/fetch_controller_if.sv
// Bundle of the program-memory, issue handshake and control signals around the fetch controller.
// master = the controller itself; slave = memory/downstream/environment side.
interface fetch_controller_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 17,
    parameter int CNT_W   = 16
);
    logic [ADDR_W-1:0]  prog_addr;
    logic [INSTR_W-1:0] prog_data;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               halt;
    logic               halted;
    logic [CNT_W-1:0]   fetch_cnt;

    modport master (
        output prog_addr, instr, instr_pc, instr_valid, halted, fetch_cnt,
        input  prog_data, instr_ready, redirect, redirect_pc, halt
    );

    modport slave (
        input  prog_addr, instr, instr_pc, instr_valid, halted, fetch_cnt,
        output prog_data, instr_ready, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, captures program memory output into an
// instruction register and issues it downstream with valid/ready, redirect and halt.
module fetch_controller #(
    parameter int              ADDR_W   = 8,
    parameter int              INSTR_W  = 17,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
    parameter int              CNT_W    = 16
) (
    input logic                clk,
    input logic                reset,
    fetch_controller_if.master bus
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               valid_q, valid_d;
    logic               halted_q, halted_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic adv_s;
    logic accept_s;

    // Handshake qualifiers: IR may load when empty or being drained this cycle.
    always_comb begin
        adv_s    = !valid_q || bus.instr_ready;
        accept_s = valid_q && bus.instr_ready;
    end

    // Next-state and datapath: redirect beats halt beats normal fetch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.redirect) begin
                    valid_d = 1'b0;
                    pc_d    = bus.redirect_pc;
                end else if (adv_s) begin
                    // A halt still takes the fetch at pc on this edge when the IR can accept it.
                    state_d    = bus.halt ? ST_HALTED : ST_RUN;
                    instr_d    = bus.prog_data;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    pc_d       = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end else begin
                    state_d = bus.halt ? ST_HALTED : ST_RUN;
                end
            end
            ST_HALTED: begin
                if (bus.redirect) begin
                    state_d = ST_RUN;
                    valid_d = 1'b0;
                    pc_d    = bus.redirect_pc;
                end else if (bus.instr_ready) begin
                    valid_d = 1'b0;
                end else begin
                    valid_d = valid_q;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
        halted_d = (state_d == ST_HALTED);
        cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, accept_s};
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            instr_q    <= {INSTR_W{1'b0}};
            instr_pc_q <= {ADDR_W{1'b0}};
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.prog_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.halted      = halted_q;
    assign bus.fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: streaming, backpressure, redirect, PC wrap,
// halt/resume and reset-over-everything, against hand-computed expectations.
module tb_fetch_controller;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    fetch_controller_if #(.ADDR_W(8), .INSTR_W(17), .CNT_W(16)) bus_if ();

    fetch_controller #(
        .ADDR_W(8), .INSTR_W(17), .RESET_PC(8'h00), .CNT_W(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    // Program memory model: distinct word per address.
    function automatic logic [16:0] mem_f(input logic [7:0] a);
        mem_f = {a[4:0], a, 4'hA};
    endfunction

    assign bus_if.prog_data = mem_f(bus_if.prog_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_issue(input string tag, input logic [7:0] pc, input logic [15:0] cnt);
        check_val({tag, ".valid"}, {31'd0, bus_if.instr_valid}, 32'd1);
        check_val({tag, ".pc"}, {24'd0, bus_if.instr_pc}, {24'd0, pc});
        check_val({tag, ".instr"}, {15'd0, bus_if.instr}, {15'd0, mem_f(pc)});
        check_val({tag, ".cnt"}, {16'd0, bus_if.fetch_cnt}, {16'd0, cnt});
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, ".valid"}, {31'd0, bus_if.instr_valid}, 32'd0);
        check_val({tag, ".instr"}, {15'd0, bus_if.instr}, 32'd0);
        check_val({tag, ".ipc"}, {24'd0, bus_if.instr_pc}, 32'd0);
        check_val({tag, ".halted"}, {31'd0, bus_if.halted}, 32'd0);
        check_val({tag, ".cnt"}, {16'd0, bus_if.fetch_cnt}, 32'd0);
        check_val({tag, ".paddr"}, {24'd0, bus_if.prog_addr}, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus_if.instr_ready = 1'b1;
        bus_if.redirect    = 1'b0;
        bus_if.redirect_pc = 8'h00;
        bus_if.halt        = 1'b0;

        // 1: reset, boot latency, streaming
        step();
        step();
        check_reset("rst");
        reset = 1'b0;
        step();
        check_val("boot.valid", {31'd0, bus_if.instr_valid}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_issue("stream", k[7:0], k[15:0]);
        end

        // 2: backpressure at instr_pc=2
        bus_if.instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_issue("hold", 8'd2, 16'd2);
            check_val("hold.paddr", {24'd0, bus_if.prog_addr}, 32'd3);
        end
        bus_if.instr_ready = 1'b1;
        step();
        check_issue("resume", 8'd3, 16'd3);

        // 3: redirect to 05 with ready=0
        bus_if.instr_ready = 1'b0;
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 8'h05;
        step();
        check_val("redir.valid", {31'd0, bus_if.instr_valid}, 32'd0);
        check_val("redir.cnt", {16'd0, bus_if.fetch_cnt}, 32'd3);
        check_val("redir.paddr", {24'd0, bus_if.prog_addr}, 32'h05);
        bus_if.redirect = 1'b0;
        step();
        check_issue("redir_tgt", 8'h05, 16'd3);

        // 4: redirect to FF with ready=1, wrap
        bus_if.instr_ready = 1'b1;
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 8'hFF;
        step();
        check_val("wrap.flush", {31'd0, bus_if.instr_valid}, 32'd0);
        check_val("wrap.cnt", {16'd0, bus_if.fetch_cnt}, 32'd4);
        bus_if.redirect = 1'b0;
        step();
        check_issue("wrap0", 8'hFF, 16'd4);
        check_val("wrap.paddr", {24'd0, bus_if.prog_addr}, 32'h00);
        for (int k = 0; k < 5; k++) begin
            step();
            check_issue("wrapn", k[7:0], 16'd5 + k[15:0]);
        end

        // 5: halt at instr_pc=4 with ready=0
        bus_if.instr_ready = 1'b0;
        bus_if.halt        = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check_val("halt.halted", {31'd0, bus_if.halted}, 32'd1);
            check_issue("halt.hold", 8'd4, 16'd9);
            check_val("halt.paddr", {24'd0, bus_if.prog_addr}, 32'd5);
        end
        bus_if.instr_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check_val("halt.drain", {31'd0, bus_if.instr_valid}, 32'd0);
            check_val("halt.cnt", {16'd0, bus_if.fetch_cnt}, 32'd10);
            check_val("halt.frozen", {24'd0, bus_if.prog_addr}, 32'd5);
            check_val("halt.still", {31'd0, bus_if.halted}, 32'd1);
        end
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 8'h00;
        bus_if.halt        = 1'b0;
        step();
        check_val("unhalt.halted", {31'd0, bus_if.halted}, 32'd0);
        check_val("unhalt.valid", {31'd0, bus_if.instr_valid}, 32'd0);
        bus_if.redirect = 1'b0;
        step();
        check_issue("unhalt", 8'd0, 16'd10);
        step();
        check_issue("unhalt2", 8'd1, 16'd11);

        // 6: reset beats redirect and halt mid-stream
        reset              = 1'b1;
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 8'h07;
        bus_if.halt        = 1'b1;
        step();
        check_reset("midrst");
        reset           = 1'b0;
        bus_if.redirect = 1'b0;
        bus_if.halt     = 1'b0;
        step();
        check_val("reboot.valid", {31'd0, bus_if.instr_valid}, 32'd0);
        step();
        check_issue("reboot", 8'd0, 16'd0);

        // Halt with IR draining still takes one last fetch
        bus_if.halt = 1'b1;
        step();
        check_issue("halt_adv", 8'd1, 16'd1);
        check_val("halt_adv.halted", {31'd0, bus_if.halted}, 32'd1);
        check_val("halt_adv.paddr", {24'd0, bus_if.prog_addr}, 32'd2);
        step();
        check_val("halt_adv.drain", {31'd0, bus_if.instr_valid}, 32'd0);
        check_val("halt_adv.cnt", {16'd0, bus_if.fetch_cnt}, 32'd2);
        check_val("halt_adv.frozen", {24'd0, bus_if.prog_addr}, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
